// File: rtl/rob_sw_retire.sv
// Reorder buffer that retires up to RETIRE_W completed entries per cycle in order,
// accepts CDB_N completions per cycle and flushes younger entries behind a mispredicted branch.
module rob_sw_retire #(
    parameter int ROB_DEPTH = 32,
    parameter int IDX_W     = $clog2(ROB_DEPTH),
    parameter int PREG_W    = 6,
    parameter int RETIRE_W  = 2,
    parameter int CDB_N     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dispatch_en_i,
    input  logic [PREG_W-1:0]            dispatch_T_i,
    input  logic [PREG_W-1:0]            dispatch_Told_i,
    input  logic [4:0]                   dispatch_areg_i,
    input  logic                         dispatch_br_i,
    output logic [IDX_W-1:0]             rob_tail_idx_o,
    output logic                         rob_full_o,
    output logic                         rob_empty_o,
    output logic [IDX_W:0]               rob_count_o,
    input  logic [CDB_N-1:0]             cdb_vld_i,
    input  logic [CDB_N*IDX_W-1:0]       cdb_idx_i,
    input  logic [CDB_N-1:0]             cdb_mispred_i,
    output logic [RETIRE_W-1:0]          retire_vld_o,
    output logic [RETIRE_W*PREG_W-1:0]   retire_T_o,
    output logic [RETIRE_W*PREG_W-1:0]   retire_Told_o,
    output logic [RETIRE_W*5-1:0]        retire_areg_o,
    output logic                         br_recover_o
);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, count, n_ret;
    logic [PREG_W-1:0] t_q    [ROB_DEPTH];
    logic [PREG_W-1:0] t_d    [ROB_DEPTH];
    logic [PREG_W-1:0] told_q [ROB_DEPTH];
    logic [PREG_W-1:0] told_d [ROB_DEPTH];
    logic [4:0]        areg_q [ROB_DEPTH];
    logic [4:0]        areg_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] br_q, br_d, done_q, done_d, mispred_q, mispred_d;

    logic [IDX_W-1:0]     cdb_idx  [CDB_N];
    logic [CDB_N-1:0]     port_ok;
    logic [ROB_DEPTH-1:0] cdb_hit, cdb_mp;
    logic [IDX_W-1:0]     slot_idx [RETIRE_W];
    logic [RETIRE_W-1:0]  slot_rdy, slot_bad;
    logic                 retire_chain;
    logic                 dispatch_ok;

    assign count          = tail_q - head_q;
    assign rob_count_o    = count;
    assign rob_full_o     = (count == PTR_W'(ROB_DEPTH));
    assign rob_empty_o    = (count == '0);
    assign rob_tail_idx_o = tail_q[IDX_W-1:0];

    // A port only counts if its index lies inside the occupied window [head, tail).
    genvar gi;
    generate
        for (gi = 0; gi < CDB_N; gi++) begin : g_port
            logic [IDX_W-1:0] offset;
            assign cdb_idx[gi]  = cdb_idx_i[gi*IDX_W +: IDX_W];
            assign offset       = cdb_idx[gi] - head_q[IDX_W-1:0];
            assign port_ok[gi]  = cdb_vld_i[gi] && ({1'b0, offset} < count);
        end

        for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
            logic [CDB_N-1:0] match;
            for (genvar gp = 0; gp < CDB_N; gp++) begin : g_match
                assign match[gp] = port_ok[gp] && (cdb_idx[gp] == IDX_W'(gi));
            end
            assign cdb_hit[gi] = |match;
            assign cdb_mp[gi]  = |(match & cdb_mispred_i);
        end

        for (gi = 0; gi < RETIRE_W; gi++) begin : g_slot
            assign slot_idx[gi] = head_q[IDX_W-1:0] + IDX_W'(gi);
            assign slot_rdy[gi] = (PTR_W'(gi) < count) && done_q[slot_idx[gi]];
            assign slot_bad[gi] = br_q[slot_idx[gi]] && mispred_q[slot_idx[gi]];
            assign retire_T_o[gi*PREG_W +: PREG_W]    = retire_vld_o[gi] ? t_q[slot_idx[gi]]    : '0;
            assign retire_Told_o[gi*PREG_W +: PREG_W] = retire_vld_o[gi] ? told_q[slot_idx[gi]] : '0;
            assign retire_areg_o[gi*5 +: 5]           = retire_vld_o[gi] ? areg_q[slot_idx[gi]] : '0;
        end
    endgenerate

    // Retire group stops at the first not-done slot or right after a mispredicted branch.
    always_comb begin
        retire_vld_o = '0;
        br_recover_o = 1'b0;
        n_ret        = '0;
        retire_chain = 1'b1;
        for (int k = 0; k < RETIRE_W; k++) begin
            if (retire_chain && slot_rdy[k]) begin
                retire_vld_o[k] = 1'b1;
                n_ret           = n_ret + 1'b1;
                if (slot_bad[k]) begin
                    br_recover_o = 1'b1;
                    retire_chain = 1'b0;
                end
            end else begin
                retire_chain = 1'b0;
            end
        end
    end

    always_comb begin
        head_d      = head_q + n_ret;
        tail_d      = tail_q;
        t_d         = t_q;
        told_d      = told_q;
        areg_d      = areg_q;
        br_d        = br_q;
        done_d      = done_q;
        mispred_d   = mispred_q;
        dispatch_ok = dispatch_en_i && !rob_full_o && !br_recover_o;
        if (br_recover_o) begin
            tail_d    = head_d;
            done_d    = '0;
            mispred_d = '0;
        end else begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (cdb_hit[e]) begin
                    done_d[e]    = 1'b1;
                    mispred_d[e] = cdb_mp[e];
                end
            end
            if (dispatch_ok) begin
                t_d[tail_q[IDX_W-1:0]]       = dispatch_T_i;
                told_d[tail_q[IDX_W-1:0]]    = dispatch_Told_i;
                areg_d[tail_q[IDX_W-1:0]]    = dispatch_areg_i;
                br_d[tail_q[IDX_W-1:0]]      = dispatch_br_i;
                done_d[tail_q[IDX_W-1:0]]    = 1'b0;
                mispred_d[tail_q[IDX_W-1:0]] = 1'b0;
                tail_d                       = tail_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            br_q      <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                t_q[e]    <= '0;
                told_q[e] <= '0;
                areg_q[e] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            t_q       <= t_d;
            told_q    <= told_d;
            areg_q    <= areg_d;
            br_q      <= br_d;
            done_q    <= done_d;
            mispred_q <= mispred_d;
        end
    end
endmodule

// File: tb/tb_rob_sw_retire.sv
// Directed bench for rob_sw_retire: stimulus pushes expected retire groups into a
// scoreboard queue, a negedge monitor pops and compares whenever a group retires.
module tb_rob_sw_retire;
    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;
    localparam int PREG_W = 6;
    localparam int RW     = 2;
    localparam int CN     = 2;

    logic              clk, rst;
    logic              dispatch_en_i, dispatch_br_i;
    logic [PREG_W-1:0] dispatch_T_i, dispatch_Told_i;
    logic [4:0]        dispatch_areg_i;
    logic [IDX_W-1:0]  rob_tail_idx_o;
    logic              rob_full_o, rob_empty_o, br_recover_o;
    logic [IDX_W:0]    rob_count_o;
    logic [CN-1:0]     cdb_vld_i, cdb_mispred_i;
    logic [CN*IDX_W-1:0] cdb_idx_i;
    logic [RW-1:0]     retire_vld_o;
    logic [RW*PREG_W-1:0] retire_T_o, retire_Told_o;
    logic [RW*5-1:0]   retire_areg_o;

    typedef struct packed {
        logic [1:0]  vld;
        logic [11:0] t;
        logic [11:0] told;
        logic [9:0]  areg;
        logic        rec;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    rob_sw_retire #(.ROB_DEPTH(DEPTH), .PREG_W(PREG_W), .RETIRE_W(RW), .CDB_N(CN)) dut (
        .clk(clk), .rst(rst),
        .dispatch_en_i(dispatch_en_i), .dispatch_T_i(dispatch_T_i),
        .dispatch_Told_i(dispatch_Told_i), .dispatch_areg_i(dispatch_areg_i),
        .dispatch_br_i(dispatch_br_i), .rob_tail_idx_o(rob_tail_idx_o),
        .rob_full_o(rob_full_o), .rob_empty_o(rob_empty_o), .rob_count_o(rob_count_o),
        .cdb_vld_i(cdb_vld_i), .cdb_idx_i(cdb_idx_i), .cdb_mispred_i(cdb_mispred_i),
        .retire_vld_o(retire_vld_o), .retire_T_o(retire_T_o), .retire_Told_o(retire_Told_o),
        .retire_areg_o(retire_areg_o), .br_recover_o(br_recover_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && retire_vld_o != '0) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_retire: got vld=%b T=%h, expected no retire", retire_vld_o, retire_T_o);
            end else begin
                mon_e = sb_q.pop_front();
                $display("[TB] retire vld=%b T=%h Told=%h areg=%h rec=%b", retire_vld_o, retire_T_o,
                         retire_Told_o, retire_areg_o, br_recover_o);
                chk("ret_vld", int'(retire_vld_o), int'(mon_e.vld));
                chk("ret_T", int'(retire_T_o), int'(mon_e.t));
                chk("ret_Told", int'(retire_Told_o), int'(mon_e.told));
                chk("ret_areg", int'(retire_areg_o), int'(mon_e.areg));
                chk("ret_recover", int'(br_recover_o), int'(mon_e.rec));
            end
        end
    end

    // Entry contents of the first run, indexed by absolute dispatch position.
    function automatic logic [5:0] ft(input int p);
        return (p < 9) ? 6'(32 + p) : 6'(p);
    endfunction
    function automatic logic [5:0] fo(input int p);
        return (p < 9) ? 6'(1 + p) : 6'((p + 7) % 64);
    endfunction
    function automatic logic [4:0] fa(input int p);
        return (p < 9) ? 5'(1 + p) : 5'(p % 32);
    endfunction

    task automatic push_exp(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] o0,
                            input logic [4:0] a0, input logic [5:0] t1, input logic [5:0] o1,
                            input logic [4:0] a1, input logic rec);
        exp_t e;
        e.vld  = v;
        e.t    = {t1, t0};
        e.told = {o1, o0};
        e.areg = {a1, a0};
        e.rec  = rec;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [5:0] t, input logic [5:0] o, input logic [4:0] a, input logic br);
        dispatch_en_i   = 1'b1;
        dispatch_T_i    = t;
        dispatch_Told_i = o;
        dispatch_areg_i = a;
        dispatch_br_i   = br;
        step();
        dispatch_en_i   = 1'b0;
        dispatch_br_i   = 1'b0;
    endtask

    task automatic cdb2(input int i0, input logic m0, input int i1, input logic m1);
        cdb_vld_i     = 2'b11;
        cdb_idx_i     = {IDX_W'(i1), IDX_W'(i0)};
        cdb_mispred_i = {m1, m0};
        step();
        cdb_vld_i     = '0;
        cdb_mispred_i = '0;
    endtask

    task automatic cdb1(input int i0, input logic m0);
        cdb_vld_i     = 2'b01;
        cdb_idx_i     = {IDX_W'(0), IDX_W'(i0)};
        cdb_mispred_i = {1'b0, m0};
        step();
        cdb_vld_i     = '0;
        cdb_mispred_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        dispatch_en_i = 1'b0; dispatch_br_i = 1'b0;
        dispatch_T_i = '0; dispatch_Told_i = '0; dispatch_areg_i = '0;
        cdb_vld_i = '0; cdb_idx_i = '0; cdb_mispred_i = '0;
        #2;
        chk("rst_count", int'(rob_count_o), 0);
        chk("rst_empty", int'(rob_empty_o), 1);
        chk("rst_full", int'(rob_full_o), 0);
        chk("rst_tail", int'(rob_tail_idx_o), 0);
        chk("rst_vld", int'(retire_vld_o), 0);
        chk("rst_recover", int'(br_recover_o), 0);
        #11 rst = 1'b0;
        step();

        for (int p = 0; p < 9; p++) disp(ft(p), fo(p), fa(p), 1'b0);
        chk("disp9_count", int'(rob_count_o), 9);
        chk("disp9_tail", int'(rob_tail_idx_o), 9);
        chk("disp9_vld", int'(retire_vld_o), 0);

        cdb1(3, 1'b0);
        push_exp(2'b01, ft(0), fo(0), fa(0), 6'd0, 6'd0, 5'd0, 1'b0);
        cdb1(0, 1'b0);
        step();
        chk("after_ret0_count", int'(rob_count_o), 8);

        push_exp(2'b11, ft(1), fo(1), fa(1), ft(2), fo(2), fa(2), 1'b0);
        push_exp(2'b01, ft(3), fo(3), fa(3), 6'd0, 6'd0, 5'd0, 1'b0);
        cdb2(1, 1'b0, 2, 1'b0);
        step();
        step();
        chk("head4_count", int'(rob_count_o), 5);

        for (int p = 9; p < 36; p++) disp(ft(p), fo(p), fa(p), 1'b0);
        chk("fill_full", int'(rob_full_o), 1);
        chk("fill_count", int'(rob_count_o), 32);
        chk("fill_tail", int'(rob_tail_idx_o), 4);
        disp(6'd1, 6'd1, 5'd1, 1'b0);
        chk("drop_count", int'(rob_count_o), 32);
        chk("drop_tail", int'(rob_tail_idx_o), 4);

        push_exp(2'b01, ft(4), fo(4), fa(4), 6'd0, 6'd0, 5'd0, 1'b0);
        cdb1(4, 1'b0);
        disp(6'd2, 6'd2, 5'd2, 1'b0);
        chk("drop_ret_count", int'(rob_count_o), 31);
        chk("drop_ret_tail", int'(rob_tail_idx_o), 4);

        for (int p = 5; p < 35; p += 2) begin
            push_exp(2'b11, ft(p), fo(p), fa(p), ft(p + 1), fo(p + 1), fa(p + 1), 1'b0);
            cdb2(p % 32, 1'b0, (p + 1) % 32, (p == 5));
        end
        push_exp(2'b01, ft(35), fo(35), fa(35), 6'd0, 6'd0, 5'd0, 1'b0);
        cdb1(35 % 32, 1'b0);
        step();
        chk("wrap_empty", int'(rob_empty_o), 1);
        chk("wrap_count", int'(rob_count_o), 0);
        chk("wrap_tail", int'(rob_tail_idx_o), 4);
        chk("wrap_full", int'(rob_full_o), 0);

        #1 rst = 1'b1;
        #2 rst = 1'b0;
        step();
        for (int p = 0; p < 7; p++) disp(6'(10 + p), 6'(20 + p), 5'(1 + p), (p == 5));
        chk("br_count", int'(rob_count_o), 7);
        push_exp(2'b11, 6'd10, 6'd20, 5'd1, 6'd11, 6'd21, 5'd2, 1'b0);
        cdb2(0, 1'b0, 1, 1'b0);
        push_exp(2'b11, 6'd12, 6'd22, 5'd3, 6'd13, 6'd23, 5'd4, 1'b0);
        cdb2(2, 1'b0, 3, 1'b0);
        cdb1(6, 1'b0);
        push_exp(2'b11, 6'd14, 6'd24, 5'd5, 6'd15, 6'd25, 5'd6, 1'b1);
        cdb2(4, 1'b0, 5, 1'b1);
        cdb_vld_i = 2'b01; cdb_idx_i = {IDX_W'(0), IDX_W'(6)}; cdb_mispred_i = 2'b01;
        disp(6'd60, 6'd61, 5'd7, 1'b0);
        cdb_vld_i = '0; cdb_mispred_i = '0;
        chk("rec_empty", int'(rob_empty_o), 1);
        chk("rec_count", int'(rob_count_o), 0);
        chk("rec_tail", int'(rob_tail_idx_o), 6);
        chk("rec_vld", int'(retire_vld_o), 0);
        chk("rec_recover", int'(br_recover_o), 0);

        for (int p = 0; p < 7; p++) disp(6'(50 + p), 6'(p), 5'(p), 1'b0);
        chk("pre_rst_count", int'(rob_count_o), 7);
        cdb1(6, 1'b0);
        chk("pre_rst_vld", int'(retire_vld_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_vld", int'(retire_vld_o), 0);
        chk("async_count", int'(rob_count_o), 0);
        chk("async_empty", int'(rob_empty_o), 1);
        chk("async_tail", int'(rob_tail_idx_o), 0);
        #3 rst = 1'b0;
        step();
        disp(6'd3, 6'd4, 5'd5, 1'b0);
        chk("post_rst_count", int'(rob_count_o), 1);
        chk("post_rst_tail", int'(rob_tail_idx_o), 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rob_sw_retire.md
Name: rob_sw_retire

Overview:
- Parametrised reorder buffer; successor to the single-retire ROB.
- Retires up to RETIRE_W done instructions per cycle, in order.
- Takes CDB_N completion ports per cycle.
- Performs retire-time branch-mispredict recovery by flushing every entry younger than the head branch.
- Sits between dispatch (map table/free list) and the architectural map/free list.

Parameters:
- ROB_DEPTH, 32, number of entries; power of two, at least 4.
- IDX_W, $clog2(ROB_DEPTH), entry index width.
- PREG_W, 6, physical register tag width.
- RETIRE_W, 2, maximum retirements per cycle; 1 to 4.
- CDB_N, 2, number of completion ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- dispatch_en_i  in  1  allocate one entry this cycle.
- dispatch_T_i  in  PREG_W  new destination tag from the free list.
- dispatch_Told_i  in  PREG_W  old destination tag from the map table.
- dispatch_areg_i  in  5  logical destination register.
- dispatch_br_i  in  1  instruction is a branch.
- rob_tail_idx_o  out  IDX_W  index the current dispatch is allocated to (sent to RS).
- rob_full_o  out  1  count == ROB_DEPTH.
- rob_empty_o  out  1  count == 0.
- rob_count_o  out  IDX_W+1  occupied entries.
- cdb_vld_i  in  CDB_N  per-port completion valid.
- cdb_idx_i  in  CDB_N*IDX_W  per-port completing entry index.
- cdb_mispred_i  in  CDB_N  per-port branch mispredicted (meaningful for branches only).
- retire_vld_o  out  RETIRE_W  slot k retires this cycle.
- retire_T_o  out  RETIRE_W*PREG_W  slot k tag, to the arch map.
- retire_Told_o  out  RETIRE_W*PREG_W  slot k old tag, to the free list.
- retire_areg_o  out  RETIRE_W*5  slot k logical destination.
- br_recover_o  out  1  mispredicted branch retiring; flush.

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits including a wrap bit.
  - Per entry: T, Told, areg, br, done, mispred.
  - count = tail - head, computed modulo 2^(IDX_W+1).
- Reset (asynchronous, immediate):
  - head = tail = 0; all done and mispred = 0.
  - Outputs: retire_vld_o = 0, br_recover_o = 0, rob_full_o = 0, rob_empty_o = 1, rob_count_o = 0, rob_tail_idx_o = 0.
  - A reset mid-operation discards all entries; no retire is reported in that cycle.
- Dispatch:
  - Accepted when dispatch_en_i && !rob_full_o && !br_recover_o.
  - On accept, at the posedge: write the entry at tail[IDX_W-1:0], clear its done and mispred, tail += 1.
  - If full, dispatch is dropped even when a retire occurs in the same cycle; full is not bypassed.
  - rob_tail_idx_o = tail[IDX_W-1:0], combinational.
- Completion:
  - For each port with cdb_vld_i, at the posedge: set done and mispred = cdb_mispred_i on entry cdb_idx_i.
  - A port whose index is outside [head, tail) is ignored.
  - Two ports writing the same index: the OR of their mispred bits is stored.
  - done takes effect at the next edge; it cannot retire in its completion cycle (one-cycle completion-to-retire latency).
- Retire (combinational from registered state):
  - Slot k (k = 0..RETIRE_W-1) examines entry head+k.
  - retire_vld_o[k] = 1 iff k < count, entry done, all slots j<k valid, and no slot j<k is a mispredicted branch.
  - Slot fields are driven from the entry; when the slot is not valid they are driven 0.
  - At the posedge, head += number of valid slots.
- Recovery:
  - br_recover_o = 1 iff some valid retire slot k holds a branch with mispred = 1.
  - That branch retires normally (its T, Told and areg are reported). Slots after it are 0.
  - At the posedge: head advances past the branch, tail = new head (ROB empty next cycle), all done and mispred cleared.
  - Dispatch and CDB writes in the recovery cycle are discarded.
- Wrap-around:
  - Index arithmetic is modulo ROB_DEPTH.
  - The wrap bit distinguishes full from empty.
  - Retire groups may straddle the DEPTH-1 to 0 boundary.
- Simultaneous dispatch and retire with no recovery: both apply; count changes by (1 - retired).

Test Plan:
- Reset, then dispatch 9 entries (T=32..40, Told=1..9, areg=1..9) -> rob_count_o=9, rob_tail_idx_o=9, retire_vld_o=00.
- CDB idx3 done, then idx0 done -> cycle after idx0: retire_vld_o=01 (T=32, Told=1); the next cycle retires nothing (entry 1 not done); idx3 stays done.
- Mark entries 1 and 2 done on both CDB ports in one cycle -> next cycle retire_vld_o=11 (T=33/34); the following cycle entry 3 retires alone; head=4.
- Fill to 32 entries -> rob_full_o=1; a 33rd dispatch is dropped and tail is unchanged; the wrap bit toggles after 32 retirements with rob_empty_o=1.
- Branch at entry 5 with mispred=1, entries 4,5,6 done, head=4 -> retire_vld_o=11, br_recover_o=1; next cycle rob_empty_o=1, head=tail=6; a dispatch in the recovery cycle is ignored.
- Assert rst asynchronously between edges while count=7 -> outputs reset immediately; retire_vld_o=0 and rob_count_o=0 before the next edge.
